riscv_bus_xbar: RTL and testbench

- Parametrised two-master / N-slave interconnect for the dual-issue core.
- Masters: ICACHE (64-bit instruction fetch) and DCACHE (32-bit load/store). Slaves: ROM, RAM, UART and any further memory-mapped devices.
- Decodes slave index from the top address bits and arbitrates per slave with round-robin fairness.
- Routes read data back through a READ_LATENCY-deep tracking pipeline with explicit rvalid strobes. Flags accesses to unmapped regions.

---
 rtl/riscv_bus_xbar_if.sv | 47 ++++
 rtl/riscv_bus_xbar.sv | 133 +++++++++++++
 tb/tb_riscv_bus_xbar.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_bus_xbar_if.sv
// Bus bundle between the two cache masters, the crossbar and its slaves.
//
// Handshake: a master raises *_req with its fields stable and holds them
// until the cycle *_accept is 1. *_accept is combinational in that same
// cycle, and the transfer completes on the following rising edge. There is
// no back-pressure on read data: *_rvalid is a one-cycle strobe that the
// master must consume.
interface riscv_bus_xbar_if #(
  parameter int NUM_SLAVES = 3
);
  // ICACHE port (read only, 64-bit)
  logic                      i_req;
  logic [31:0]               i_addr;
  logic                      i_accept;
  logic [63:0]               i_rdata;
  logic                      i_rvalid;
  // DCACHE port (32-bit load/store)
  logic                      d_req;
  logic                      d_ren;
  logic [3:0]                d_wen;
  logic [31:0]               d_addr;
  logic [31:0]               d_wdata;
  logic                      d_accept;
  logic [31:0]               d_rdata;
  logic                      d_rvalid;
  logic                      d_err;
  // Slave side, slice k belongs to slave k
  logic [NUM_SLAVES*32-1:0]  s_addr;
  logic [NUM_SLAVES*32-1:0]  s_wdata;
  logic [NUM_SLAVES*4-1:0]   s_wen;
  logic [NUM_SLAVES-1:0]     s_ren;
  logic [NUM_SLAVES*64-1:0]  s_rdata;

  // Environment view: caches drive requests, slaves drive read data.
  modport master (
    output i_req, i_addr, d_req, d_ren, d_wen, d_addr, d_wdata, s_rdata,
    input  i_accept, i_rdata, i_rvalid, d_accept, d_rdata, d_rvalid, d_err,
           s_addr, s_wdata, s_wen, s_ren
  );

  // Crossbar view.
  modport slave (
    input  i_req, i_addr, d_req, d_ren, d_wen, d_addr, d_wdata, s_rdata,
    output i_accept, i_rdata, i_rvalid, d_accept, d_rdata, d_rvalid, d_err,
           s_addr, s_wdata, s_wen, s_ren
  );
endinterface

// File: rtl/riscv_bus_xbar.sv
// Two-master (ICACHE, DCACHE) to NUM_SLAVES crossbar with per-slave
// round-robin arbitration, unmapped-region detection and fixed-latency
// read-data return tracking.
module riscv_bus_xbar #(
  parameter int NUM_SLAVES   = 3,
  parameter int SEL_W        = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  srst_n,
  riscv_bus_xbar_if.slave       bus,
  output logic [NUM_SLAVES-1:0] rr_ptr
);

  localparam int LAST = READ_LATENCY - 1;

  logic [SEL_W-1:0]      i_tgt, d_tgt;
  logic                  i_mapped, d_mapped;
  logic [NUM_SLAVES-1:0] i_hit, d_hit, i_grant, d_grant;
  logic                  i_acc, d_acc;

  // Tracking pipelines: stage 0 is loaded on accept, stage LAST is the output.
  logic [READ_LATENCY-1:0]            i_pv, i_pu;
  logic [READ_LATENCY-1:0][SEL_W-1:0] i_pidx;
  logic [READ_LATENCY-1:0]            d_pv, d_pu, d_pa2;
  logic [READ_LATENCY-1:0][SEL_W-1:0] d_pidx;

  logic [63:0] i_sel, d_sel;

  assign i_tgt    = bus.i_addr[31 -: SEL_W];
  assign d_tgt    = bus.d_addr[31 -: SEL_W];
  assign i_mapped = {{(32-SEL_W){1'b0}}, i_tgt} < NUM_SLAVES;
  assign d_mapped = {{(32-SEL_W){1'b0}}, d_tgt} < NUM_SLAVES;

  // Decode targets and resolve per-slave contention with the rr pointer.
  always_comb begin
    i_hit   = '0;
    d_hit   = '0;
    i_grant = '0;
    d_grant = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      i_hit[k]   = srst_n & bus.i_req & (i_tgt == SEL_W'(k));
      d_hit[k]   = srst_n & bus.d_req & (d_tgt == SEL_W'(k));
      i_grant[k] = i_hit[k] & (~d_hit[k] | ~rr_ptr[k]);
      d_grant[k] = d_hit[k] & (~i_hit[k] |  rr_ptr[k]);
    end
    // Unmapped requests never contend, so they are accepted at once.
    i_acc = srst_n & bus.i_req & (~i_mapped | (|i_grant));
    d_acc = srst_n & bus.d_req & (~d_mapped | (|d_grant));
  end

  assign bus.i_accept = i_acc;
  assign bus.d_accept = d_acc;

  // Forward the granted master onto each slave slice; idle slices are zero.
  always_comb begin
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_wen   = '0;
    bus.s_ren   = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (i_grant[k]) begin
        bus.s_addr[k*32 +: 32] = bus.i_addr;
        bus.s_ren[k]           = 1'b1;
      end else if (d_grant[k]) begin
        bus.s_addr[k*32 +: 32]  = bus.d_addr;
        bus.s_wdata[k*32 +: 32] = bus.d_wdata;
        bus.s_wen[k*4 +: 4]     = bus.d_wen;
        bus.s_ren[k]            = bus.d_ren;
      end
    end
  end

  // Round-robin pointer flips only when both masters hit the same slave.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_ptr ^ (i_hit & d_hit);
    end
  end

  // Shift the read-tracking pipelines every cycle; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      i_pv   <= '0;
      i_pu   <= '0;
      i_pidx <= '0;
      d_pv   <= '0;
      d_pu   <= '0;
      d_pa2  <= '0;
      d_pidx <= '0;
    end else begin
      for (int s = READ_LATENCY - 1; s > 0; s--) begin
        i_pv[s]   <= i_pv[s-1];
        i_pu[s]   <= i_pu[s-1];
        i_pidx[s] <= i_pidx[s-1];
        d_pv[s]   <= d_pv[s-1];
        d_pu[s]   <= d_pu[s-1];
        d_pa2[s]  <= d_pa2[s-1];
        d_pidx[s] <= d_pidx[s-1];
      end
      i_pv[0]   <= i_acc;
      i_pu[0]   <= ~i_mapped;
      i_pidx[0] <= i_tgt;
      // A combined read+write is tracked as a read; a pure write is not.
      d_pv[0]   <= d_acc & bus.d_ren;
      d_pu[0]   <= ~d_mapped;
      d_pa2[0]  <= bus.d_addr[2];
      d_pidx[0] <= d_tgt;
    end
  end

  // Steer the recorded slave's data back; zero data when invalid or unmapped.
  always_comb begin
    i_sel = '0;
    d_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (i_pidx[LAST] == SEL_W'(k)) i_sel = bus.s_rdata[k*64 +: 64];
      if (d_pidx[LAST] == SEL_W'(k)) d_sel = bus.s_rdata[k*64 +: 64];
    end
    bus.i_rvalid = i_pv[LAST];
    bus.i_rdata  = (i_pv[LAST] & ~i_pu[LAST]) ? i_sel : 64'd0;
    bus.d_rvalid = d_pv[LAST];
    bus.d_rdata  = '0;
    if (d_pv[LAST] & ~d_pu[LAST]) begin
      bus.d_rdata = d_pa2[LAST] ? d_sel[63:32] : d_sel[31:0];
    end
    // Unmapped reads flag on return; unmapped non-reads flag on accept.
    bus.d_err = (d_pv[LAST] & d_pu[LAST]) | (d_acc & ~d_mapped & ~bus.d_ren);
  end

endmodule

// File: tb/tb_riscv_bus_xbar.sv
// Self-checking bench for riscv_bus_xbar: directed scenarios followed by
// random traffic, with a per-cycle reference model and read scoreboards.
module tb_riscv_bus_xbar;

  localparam int NS = 3;
  localparam int RL = 2;

  logic clk;
  logic srst_n;
  logic [NS-1:0] rr_ptr;

  riscv_bus_xbar_if #(.NUM_SLAVES(NS)) bus ();

  riscv_bus_xbar #(.NUM_SLAVES(NS), .SEL_W(4), .READ_LATENCY(RL)) dut (
    .clk    (clk),
    .srst_n (srst_n),
    .bus    (bus),
    .rr_ptr (rr_ptr)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- slave models ----------------
  logic [63:0] ovr_data [NS];
  logic        ovr_en   [NS];
  logic [RL-1:0] sv [NS];
  logic [31:0]   sa [NS][RL];

  function automatic logic [63:0] slave_word(input int k, input logic [31:0] a);
    if (ovr_en[k]) return ovr_data[k];
    return {a ^ 32'h5A5A_0000 ^ 32'(k), ~a};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (!srst_n) begin
        sv[k] <= '0;
      end else begin
        for (int s = RL - 1; s > 0; s--) begin
          sv[k][s] <= sv[k][s-1];
          sa[k][s] <= sa[k][s-1];
        end
        sv[k][0] <= bus.s_ren[k];
        sa[k][0] <= bus.s_addr[k*32 +: 32];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NS; k++) begin
      bus.s_rdata[k*64 +: 64] = sv[k][RL-1] ? slave_word(k, sa[k][RL-1]) : 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [63:0] i_exp_q[$];
  int          i_due_q[$];
  logic [32:0] d_exp_q[$];
  int          d_due_q[$];
  logic [NS-1:0] tb_rr = '0;
  logic m_ia, m_da;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model of one cycle: compares combinational outputs and
  // returning reads, then advances the model state.
  task automatic monitor();
    logic [3:0]  it, dt;
    logic        im, dm, ev, ee;
    logic [NS-1:0] ih, dh, ig, dg, eren;
    logic [NS*32-1:0] ea, ew;
    logic [NS*4-1:0]  ewen;
    logic [63:0] gi, wd;
    logic [32:0] gd;
    cyc++;
    it = bus.i_addr[31:28];
    dt = bus.d_addr[31:28];
    im = it < NS;
    dm = dt < NS;
    ea = '0; ew = '0; ewen = '0; eren = '0;
    for (int k = 0; k < NS; k++) begin
      ih[k] = srst_n && bus.i_req && (int'(it) == k);
      dh[k] = srst_n && bus.d_req && (int'(dt) == k);
      ig[k] = ih[k] && (!dh[k] || !tb_rr[k]);
      dg[k] = dh[k] && (!ih[k] || tb_rr[k]);
      if (ig[k]) begin
        ea[k*32 +: 32] = bus.i_addr;
        eren[k] = 1'b1;
      end else if (dg[k]) begin
        ea[k*32 +: 32]  = bus.d_addr;
        ew[k*32 +: 32]  = bus.d_wdata;
        ewen[k*4 +: 4]  = bus.d_wen;
        eren[k]         = bus.d_ren;
      end
    end
    m_ia = srst_n && bus.i_req && (!im || (|ig));
    m_da = srst_n && bus.d_req && (!dm || (|dg));
    check("i_accept", bus.i_accept, m_ia);
    check("d_accept", bus.d_accept, m_da);
    check("s_ren",    bus.s_ren,    eren);
    check("s_wen",    bus.s_wen,    ewen);
    check("s_addr",   bus.s_addr,   ea);
    check("s_wdata",  bus.s_wdata,  ew);
    check("rr_ptr",   rr_ptr,       tb_rr);
    // ICACHE returns
    while (i_due_q.size() > 0 && i_due_q[0] < cyc) begin
      check("i_lost", i_due_q.pop_front(), cyc);
      void'(i_exp_q.pop_front());
    end
    ev = (i_due_q.size() > 0) && (i_due_q[0] == cyc);
    check("i_rvalid", bus.i_rvalid, ev);
    if (ev) begin
      void'(i_due_q.pop_front());
      gi = i_exp_q.pop_front();
      check("i_rdata", bus.i_rdata, gi);
    end else begin
      check("i_rdata_idle", bus.i_rdata, 64'd0);
    end
    // DCACHE returns
    while (d_due_q.size() > 0 && d_due_q[0] < cyc) begin
      check("d_lost", d_due_q.pop_front(), cyc);
      void'(d_exp_q.pop_front());
    end
    ev = (d_due_q.size() > 0) && (d_due_q[0] == cyc);
    ee = m_da && !dm && !bus.d_ren;
    check("d_rvalid", bus.d_rvalid, ev);
    if (ev) begin
      void'(d_due_q.pop_front());
      gd = d_exp_q.pop_front();
      ee = ee | gd[32];
      check("d_rdata", bus.d_rdata, gd[31:0]);
    end else begin
      check("d_rdata_idle", bus.d_rdata, 32'd0);
    end
    check("d_err", bus.d_err, ee);
    // advance model
    if (!srst_n) begin
      i_exp_q.delete(); i_due_q.delete();
      d_exp_q.delete(); d_due_q.delete();
      tb_rr = '0;
    end else begin
      if (m_ia) begin
        i_exp_q.push_back(im ? slave_word(int'(it), bus.i_addr) : 64'd0);
        i_due_q.push_back(cyc + RL);
      end
      if (m_da && bus.d_ren) begin
        wd = dm ? slave_word(int'(dt), bus.d_addr) : 64'd0;
        d_exp_q.push_back({!dm, bus.d_addr[2] ? wd[63:32] : wd[31:0]});
        d_due_q.push_back(cyc + RL);
      end
      tb_rr = tb_rr ^ (ih & dh);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_ren = 1'b0; bus.d_wen = '0;
    bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic drive_i(input logic [31:0] a);
    bus.i_req = 1'b1; bus.i_addr = a;
  endtask

  task automatic drive_d(input logic ren, input logic [3:0] wen,
                         input logic [31:0] a, input logic [31:0] wd);
    bus.d_req = 1'b1; bus.d_ren = ren; bus.d_wen = wen;
    bus.d_addr = a; bus.d_wdata = wd;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    for (int k = 0; k < NS; k++) begin
      ovr_en[k] = 1'b0;
      ovr_data[k] = '0;
    end
    idle();
    srst_n = 1'b0;
    drive_i(32'h0000_0000);
    drive_d(1'b1, 4'h0, 32'h0000_0004, '0);
    @(negedge clk);

    // Reset: requests held during reset are refused, outputs stay zero.
    for (int n = 0; n < 2; n++) begin
      #1;
      check("rst_i_accept", bus.i_accept, 1'b0);
      check("rst_d_accept", bus.d_accept, 1'b0);
      check("rst_s_ren", bus.s_ren, 3'b000);
      tick();
    end
    srst_n = 1'b1;
    idle();
    tick();

    // Read routing to RAM
    ovr_en[1] = 1'b1; ovr_data[1] = 64'hDEAD_BEEF_0123_4567;
    drive_i(32'h1000_0008);
    #1;
    check("rt_i_accept", bus.i_accept, 1'b1);
    check("rt_s_ren", bus.s_ren, 3'b010);
    tick();
    idle();
    tick();
    #1;
    check("rt_i_rvalid", bus.i_rvalid, 1'b1);
    check("rt_i_rdata", bus.i_rdata, 64'hDEAD_BEEF_0123_4567);
    tick();
    tick();
    ovr_en[1] = 1'b0;

    // Contention on ROM: grants alternate I, D, I, D
    drive_i(32'h0000_0000);
    drive_d(1'b1, 4'h0, 32'h0000_0004, '0);
    for (int n = 0; n < 4; n++) begin
      #1;
      check("ct_i_accept", bus.i_accept, (n % 2) == 0);
      check("ct_d_accept", bus.d_accept, (n % 2) == 1);
      tick();
    end
    idle();
    #1;
    check("ct_rr_end", rr_ptr[0], 1'b0);
    for (int n = 0; n < 3; n++) tick();

    // Parallel grant: ICACHE to ROM, DCACHE write to UART
    drive_i(32'h0000_0000);
    drive_d(1'b0, 4'b0001, 32'h2000_0000, 32'h41);
    #1;
    check("pg_i_accept", bus.i_accept, 1'b1);
    check("pg_d_accept", bus.d_accept, 1'b1);
    check("pg_s_wen", bus.s_wen[11:8], 4'b0001);
    check("pg_s_wdata", bus.s_wdata[95:64], 32'h41);
    tick();
    idle();
    for (int n = 0; n < 3; n++) tick();

    // Word select from ROM
    ovr_en[0] = 1'b1; ovr_data[0] = 64'h1111_2222_3333_4444;
    drive_d(1'b1, 4'h0, 32'h0000_0004, '0);
    tick();
    drive_d(1'b1, 4'h0, 32'h0000_0000, '0);
    tick();
    idle();
    #1;
    check("ws_hi", bus.d_rdata, 32'h1111_2222);
    tick();
    #1;
    check("ws_lo", bus.d_rdata, 32'h3333_4444);
    tick();
    ovr_en[0] = 1'b0;

    // Unmapped DCACHE read
    drive_d(1'b1, 4'h0, 32'h5000_0000, '0);
    #1;
    check("um_d_accept", bus.d_accept, 1'b1);
    check("um_s_ren", bus.s_ren, 3'b000);
    tick();
    idle();
    tick();
    #1;
    check("um_d_rvalid", bus.d_rvalid, 1'b1);
    check("um_d_err", bus.d_err, 1'b1);
    check("um_d_rdata", bus.d_rdata, 32'd0);
    tick();

    // Reset mid-flight
    drive_i(32'h0000_0008);
    tick();
    idle();
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    #1;
    check("rm_i_rvalid", bus.i_rvalid, 1'b0);
    check("rm_rr_ptr", rr_ptr, 3'b000);
    tick();
    tick();

    // Random traffic, each master holding its request until accepted
    m_ia = 1'b0; m_da = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (m_ia || !bus.i_req) begin
        bus.i_req  = ($urandom_range(0, 3) != 0);
        bus.i_addr = {4'($urandom_range(0, 4)), 25'($urandom), 3'b000};
      end
      if (m_da || !bus.d_req) begin
        kind = $urandom_range(0, 2);
        bus.d_req   = ($urandom_range(0, 3) != 0);
        bus.d_addr  = {4'($urandom_range(0, 4)), 28'($urandom)};
        bus.d_wdata = $urandom;
        bus.d_ren   = (kind != 1);
        bus.d_wen   = (kind == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      tick();
    end
    idle();
    for (int n = 0; n < 10; n++) begin
      if (i_due_q.size() == 0 && d_due_q.size() == 0) break;
      tick();
    end
    check("drain_i", i_due_q.size(), 0);
    check("drain_d", d_due_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
